// File: rtl/spi_master15.sv
// SPI master for the 15-bit LOAD-framed link: LOAD pulse, N SCLK cycles MSB-first
// full duplex, a one half-period gap, then a closing LOAD pulse. All pins are registered.
module spi_master15 #(
    parameter int N   = 15,
    parameter int DIV = 25
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         st,
    input  logic [N-1:0] TX_DAT,
    output logic [N-1:0] RX_DAT,
    output logic         busy,
    output logic         done,
    output logic         SCLK,
    output logic         MOSI,
    input  logic         MISO,
    output logic         LOAD
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int KW = $clog2(2 * N);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(2 * N - 1);

    typedef enum logic [2:0] {IDLE, LOAD1, SHIFT, GAP, LOAD2} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [KW-1:0] k_reg, k_next;
    logic [N-1:0]  tx_sr_reg, tx_sr_next;
    logic [N-1:0]  rx_sr_reg, rx_sr_next;
    logic [N-1:0]  rx_dat_reg, rx_dat_next;
    logic          sclk_reg, sclk_next;
    logic          load_reg, load_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          tick, last_k, rise, fall;

    assign tick   = (state_reg != IDLE) && (cnt_reg == CNT_LAST);
    assign last_k = (k_reg == K_LAST);
    assign rise   = (state_reg == SHIFT) && tick && !k_reg[0];
    // The final fall leaves SHIFT without shifting, so MOSI keeps the last bit.
    assign fall   = (state_reg == SHIFT) && tick && k_reg[0] && !last_k;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            k_reg      <= '0;
            tx_sr_reg  <= '0;
            rx_sr_reg  <= '0;
            rx_dat_reg <= '0;
            sclk_reg   <= 1'b0;
            load_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            k_reg      <= k_next;
            tx_sr_reg  <= tx_sr_next;
            rx_sr_reg  <= rx_sr_next;
            rx_dat_reg <= rx_dat_next;
            sclk_reg   <= sclk_next;
            load_reg   <= load_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = (state_reg == IDLE || tick) ? '0 : cnt_reg + 1'b1;
        k_next      = k_reg;
        tx_sr_next  = tx_sr_reg;
        rx_sr_next  = rx_sr_reg;
        rx_dat_next = rx_dat_reg;
        case (state_reg)
            IDLE: begin
                if (st) begin
                    state_next = LOAD1;
                    tx_sr_next = TX_DAT;
                end
            end
            LOAD1: begin
                k_next = '0;
                if (tick) state_next = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (last_k) state_next = GAP;
                    else        k_next     = k_reg + 1'b1;
                end
            end
            GAP: begin
                if (tick) state_next = LOAD2;
            end
            LOAD2: begin
                if (tick) begin
                    state_next  = IDLE;
                    rx_dat_next = rx_sr_reg;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rise) rx_sr_next = {rx_sr_reg[N-2:0], MISO};
        if (fall) tx_sr_next = {tx_sr_reg[N-2:0], 1'b0};
    end

    // Pin values are decoded from the next state so they leave the flops glitch-free.
    always_comb begin
        load_next = (state_next == LOAD1) || (state_next == LOAD2);
        sclk_next = (state_next == SHIFT) && k_next[0];
        busy_next = (state_next != IDLE);
        done_next = (state_reg == LOAD2) && tick;
    end

    assign SCLK   = sclk_reg;
    assign LOAD   = load_reg;
    assign MOSI   = tx_sr_reg[N-1];
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign RX_DAT = rx_dat_reg;
endmodule

// File: tb/tb_spi_master15.sv
// Bench for spi_master15 (DIV=4): frame-level model compared every cycle, a behavioural
// 15-bit slave, pin-timing monitors and directed literal checks.
module tb_spi_master15;
    localparam int N     = 15;
    localparam int DIV   = 4;
    localparam int FRAME = (2 * N + 3) * DIV;

    logic         clk = 1'b0;
    logic         clr_n, st, MISO;
    logic [N-1:0] TX_DAT, RX_DAT;
    logic         busy, done, SCLK, MOSI, LOAD;

    logic         loopback;
    logic [N-1:0] slave_di;
    logic [N-1:0] s_tx, s_rx, s_do;
    logic         chk_en;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    spi_master15 #(.N(N), .DIV(DIV)) dut (
        .clk(clk), .clr_n(clr_n), .st(st), .TX_DAT(TX_DAT), .RX_DAT(RX_DAT),
        .busy(busy), .done(done), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .LOAD(LOAD)
    );

    assign MISO = loopback ? MOSI : s_tx[N-1];

    // Slave: every LOAD rise latches the received word and preloads DI; shifts out on SCLK fall.
    always @(posedge LOAD or negedge SCLK) begin
        if (LOAD) s_tx <= slave_di;
        else      s_tx <= {s_tx[N-2:0], 1'b0};
    end
    always @(posedge SCLK) s_rx <= {s_rx[N-2:0], MOSI};
    always @(posedge LOAD) s_do <= s_rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is FRAME clocks of half-period phases after acceptance.
    logic         m_active = 1'b0, m_done = 1'b0, m_hold = 1'b0;
    int           m_t = 0;
    logic [N-1:0] m_tx = '0, m_rx = '0;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_hold   <= 1'b0;
            m_t      <= 0;
            m_rx     <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_t == FRAME - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_rx     <= loopback ? m_tx : slave_di;
                    m_hold   <= m_tx[0];
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (st) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_tx     <= TX_DAT;
            end
        end
    end

    int   p, idx;
    logic e_load, e_sclk, e_mosi, e_busy;
    logic sclk_q = 1'b0, load_q = 1'b0, mosi_q = 1'b0;
    int   stable_cnt = 1000;
    int   rises = 0, loads = 0, dones = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            p = m_t / DIV;
            if (m_active) begin
                e_load = (p == 0) || (p == 2 * N + 2);
                e_sclk = (p >= 1) && (p <= 2 * N) && (((p - 1) % 2) == 1);
                if (p == 0)          idx = N - 1;
                else if (p <= 2 * N) idx = N - 1 - (p - 1) / 2;
                else                 idx = 0;
                e_mosi = m_tx[idx];
                e_busy = 1'b1;
            end else begin
                e_load = 1'b0;
                e_sclk = 1'b0;
                e_mosi = m_hold;
                e_busy = 1'b0;
            end
            check("LOAD", LOAD, e_load);
            check("SCLK", SCLK, e_sclk);
            check("MOSI", MOSI, e_mosi);
            check("busy", busy, e_busy);
            check("done", done, m_done);
            check("RX_DAT", RX_DAT, m_rx);
            if (SCLK && !sclk_q)
                check("mosi_setup", (MOSI == mosi_q) && (stable_cnt >= DIV - 1), 1);
            if (LOAD && !load_q)
                check("load_vs_sclk_fall", !(sclk_q && !SCLK), 1);
            if (LOAD)
                check("sclk_low_in_load", SCLK, 0);
            if (done)
                $display("frame: rx=%04h busy=%0d t=%0t", RX_DAT, busy, $time);
        end
        rises      <= rises + ((SCLK && !sclk_q) ? 1 : 0);
        loads      <= loads + ((LOAD && !load_q) ? 1 : 0);
        dones      <= dones + (done ? 1 : 0);
        stable_cnt <= (MOSI != mosi_q) ? 0 : ((stable_cnt < 1000) ? stable_cnt + 1 : stable_cnt);
        sclk_q     <= SCLK;
        load_q     <= LOAD;
        mosi_q     <= MOSI;
    end

    // Counts negedges after the one following st until done is seen (bounded).
    task automatic wait_done(inout int cyc);
        while (!done && cyc < 4 * FRAME) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    int cyc, r0, l0, d0;

    initial begin
        clr_n = 1'b0; st = 1'b0; TX_DAT = '0; loopback = 1'b1; slave_di = '0; chk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", SCLK, 0);
        check("rst_load", LOAD, 0);
        check("rst_busy", busy, 0);
        check("rst_rx", RX_DAT, 0);
        chk_en = 1'b1;
        @(negedge clk) clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback 2A5A with latency and edge counts
        r0 = rises; l0 = loads;
        TX_DAT = 15'h2A5A; st = 1'b1;
        @(negedge clk); cyc = 1; st = 1'b0;
        wait_done(cyc);
        check("latency", cyc, 133);
        check("rx_loop", RX_DAT, 15'h2A5A);
        @(negedge clk);
        check("sclk_rises", rises - r0, 15);
        check("load_pulses", loads - l0, 2);

        // Behavioural slave
        loopback = 1'b0; slave_di = 15'h7FFF;
        TX_DAT = 15'h0001; st = 1'b1;
        @(negedge clk); cyc = 1; st = 1'b0;
        wait_done(cyc);
        check("rx_slave", RX_DAT, 15'h7FFF);
        check("slave_do", s_do, 15'h0001);
        @(negedge clk);

        // st during SHIFT is ignored
        loopback = 1'b1; d0 = dones;
        TX_DAT = 15'h1234; st = 1'b1;
        @(negedge clk); cyc = 1; st = 1'b0;
        repeat (40) begin @(negedge clk); cyc++; end
        TX_DAT = 15'h5555; st = 1'b1;
        @(negedge clk); cyc++; st = 1'b0;
        wait_done(cyc);
        check("rx_busy_ignore", RX_DAT, 15'h1234);
        repeat (20) @(negedge clk);
        check("one_done", dones - d0, 1);
        check("idle_after_ignore", busy, 0);

        // Back-to-back with st held high
        TX_DAT = 15'h0F0F; st = 1'b1;
        @(negedge clk); cyc = 1;
        wait_done(cyc);
        check("b2b_rx1", RX_DAT, 15'h0F0F);
        check("b2b_busy_gap", busy, 0);
        TX_DAT = 15'h70F0;
        @(negedge clk); cyc = 1;
        check("b2b_load1", LOAD, 1);
        check("b2b_busy_again", busy, 1);
        st = 1'b0;
        wait_done(cyc);
        check("b2b_rx2", RX_DAT, 15'h70F0);
        @(negedge clk);

        // Reset mid-SHIFT while SCLK is high
        d0 = dones;
        TX_DAT = 15'h7ABC; st = 1'b1;
        @(negedge clk); st = 1'b0;
        repeat (50) @(negedge clk);
        @(posedge clk); #1;
        check("pre_reset_sclk", SCLK, 1);
        #1 clr_n = 1'b0;
        #1;
        check("abort_sclk", SCLK, 0);
        check("abort_load", LOAD, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rx", RX_DAT, 0);
        repeat (5) @(negedge clk);
        clr_n = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        check("abort_no_done", dones - d0, 0);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_load", LOAD, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
